// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 3-bit-opcode ALU32: maps RISC-V R-type ops onto
// ALU ops, builds shifts from single-bit ALU shifts and derives SLT/SLTU from the ALU difference.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; operands/op latched on accept
//   EXEC  | single ALU op in flight; alu_out captured at the end
//   SHIFT | one single-bit ALU shift per cycle until counter reaches 1
//   RESP  | result held on rsp_data/rsp_err until consumer takes it
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic            i_req_funct7b5,
    input  logic [XLEN-1:0] i_req_rs1,
    input  logic [XLEN-1:0] i_req_rs2,
    output logic [XLEN-1:0] o_alu_in0,
    output logic [XLEN-1:0] o_alu_in1,
    output logic [2:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_out,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_SHR1 = 3'd6;
    localparam logic [2:0] OP_SHL1 = 3'd7;

    state_t          r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_alu_in0;
    logic [XLEN-1:0] r_alu_in1;
    logic [2:0]      r_alu_op;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_err;
    logic            r_is_slt;
    logic            r_is_sltu;

    logic            w_a31;
    logic            w_b31;
    logic            w_d31;
    logic            w_same_sign;
    logic            w_lt_signed;
    logic            w_lt_unsigned;
    logic [4:0]      w_shamt;

    // Comparisons from the sign bits of the operands and of the difference a-b.
    assign w_a31         = r_alu_in0[XLEN-1];
    assign w_b31         = r_alu_in1[XLEN-1];
    assign w_d31         = i_alu_out[XLEN-1];
    assign w_same_sign   = ~(w_a31 ^ w_b31);
    assign w_lt_signed   = (w_a31 & ~w_b31) | (w_same_sign & w_d31);
    assign w_lt_unsigned = (~w_a31 & w_b31) | (w_same_sign & w_d31);
    assign w_shamt       = i_req_rs2[4:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_alu_in0  <= '0;
            r_alu_in1  <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_is_slt   <= 1'b0;
            r_is_sltu  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_alu_in0 <= i_req_rs1;
                        r_alu_in1 <= i_req_rs2;
                        r_rsp_err <= 1'b0;
                        r_is_slt  <= 1'b0;
                        r_is_sltu <= 1'b0;
                        case (i_req_funct3)
                            3'b000: begin
                                r_alu_op <= i_req_funct7b5 ? OP_SUB : OP_ADD;
                                r_state  <= EXEC;
                            end
                            3'b111: begin
                                r_alu_op <= OP_AND;
                                r_state  <= EXEC;
                            end
                            3'b110: begin
                                r_alu_op <= OP_OR;
                                r_state  <= EXEC;
                            end
                            3'b010: begin
                                r_alu_op <= OP_SLT;
                                r_is_slt <= 1'b1;
                                r_state  <= EXEC;
                            end
                            3'b011: begin
                                r_alu_op  <= OP_SLT;
                                r_is_sltu <= 1'b1;
                                r_state   <= EXEC;
                            end
                            3'b001, 3'b101: begin
                                if (i_req_funct3 == 3'b101 && i_req_funct7b5) begin
                                    r_rsp_err  <= 1'b1;
                                    r_rsp_data <= '0;
                                    r_state    <= RESP;
                                end else begin
                                    r_alu_op  <= (i_req_funct3 == 3'b001) ? OP_SHL1 : OP_SHR1;
                                    r_alu_in1 <= '0;
                                    if (w_shamt == 5'd0) begin
                                        r_rsp_data <= i_req_rs1;
                                        r_state    <= RESP;
                                    end else begin
                                        r_cnt   <= w_shamt;
                                        r_state <= SHIFT;
                                    end
                                end
                            end
                            default: begin
                                r_rsp_err  <= 1'b1;
                                r_rsp_data <= '0;
                                r_state    <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (r_is_slt)
                        r_rsp_data <= {{(XLEN-1){1'b0}}, w_lt_signed};
                    else if (r_is_sltu)
                        r_rsp_data <= {{(XLEN-1){1'b0}}, w_lt_unsigned};
                    else
                        r_rsp_data <= i_alu_out;
                    r_state <= RESP;
                end
                SHIFT: begin
                    r_alu_in0 <= i_alu_out;
                    r_cnt     <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_rsp_data <= i_alu_out;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = (r_state == RESP);
    assign o_alu_in0   = r_alu_in0;
    assign o_alu_in1   = r_alu_in1;
    assign o_alu_op    = r_alu_op;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU32 beside the DUT, directed and random
// requests checked against an arithmetic reference of result, error flag and latency.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_pass;
    int n_total;
    int n_fail;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_funct3   (req_funct3),
        .i_req_funct7b5 (req_funct7b5),
        .i_req_rs1      (req_rs1),
        .i_req_rs2      (req_rs2),
        .o_alu_in0      (alu_in0),
        .o_alu_in1      (alu_in1),
        .o_alu_op       (alu_op),
        .i_alu_out      (alu_out),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU32 environment model
    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'd0: alu_out = alu_in0 & alu_in1;
            3'd1: alu_out = alu_in0 | alu_in1;
            3'd2: alu_out = alu_in0 + alu_in1;
            3'd3: alu_out = alu_in0 - alu_in1;
            3'd4: alu_out = alu_in0 - alu_in1;
            3'd5: alu_out = ~(alu_in0 | alu_in1);
            3'd6: alu_out = alu_in0 >> 1;
            3'd7: alu_out = alu_in0 << 1;
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, error, response latency (edges after accept), expected ALU op.
    task automatic ref_model(input logic [2:0] f3, input logic b5,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] data, output logic err,
                             output int lat, output logic [2:0] op, output logic single);
        int n;
        n = int'(b[4:0]);
        data = 32'd0; err = 1'b0; lat = 1; op = 3'd0; single = 1'b1;
        case (f3)
            3'b000: begin data = b5 ? a - b : a + b; op = b5 ? 3'd3 : 3'd2; end
            3'b111: begin data = a & b; op = 3'd0; end
            3'b110: begin data = a | b; op = 3'd1; end
            3'b010: begin data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; op = 3'd4; end
            3'b011: begin data = (a < b) ? 32'd1 : 32'd0; op = 3'd4; end
            3'b001: begin data = a << n; lat = n; single = 1'b0; op = 3'd7; end
            3'b101: begin
                single = 1'b0;
                if (b5) begin err = 1'b1; lat = 0; end
                else begin data = a >> n; lat = n; op = 3'd6; end
            end
            default: begin err = 1'b1; lat = 0; single = 1'b0; end
        endcase
    endtask

    task automatic do_req(input logic [2:0] f3, input logic b5,
                          input logic [31:0] a, input logic [31:0] b, input int bp);
        logic [31:0] e_data;
        logic        e_err;
        logic [2:0]  e_op;
        logic        e_single;
        int          e_lat;
        int          cyc;
        ref_model(f3, b5, a, b, e_data, e_err, e_lat, e_op, e_single);
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 40) begin @(negedge clk); cyc++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_funct7b5 = b5; req_rs1 = a; req_rs2 = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
        @(negedge clk);
        if (e_single) begin
            chk("exec_alu_op", {29'd0, alu_op}, {29'd0, e_op});
            chk("exec_alu_in0", alu_in0, a);
        end
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        chk("latency", cyc, e_lat);
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_data", rsp_data, e_data);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0] f3;
        n_pass = 0; n_total = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = '0; req_funct7b5 = 1'b0; req_rs1 = '0; req_rs2 = '0;
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_in0", alu_in0, 32'd0);
        chk("rst_op", {29'd0, alu_op}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(3'b000, 1'b0, 32'd5, 32'd7, 0);
        do_req(3'b000, 1'b1, 32'd1, 32'd1, 0);
        do_req(3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_req(3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_req(3'b010, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_req(3'b001, 1'b0, 32'd1, 32'd31, 0);
        do_req(3'b101, 1'b0, 32'h8000_0000, 32'd4, 0);
        do_req(3'b101, 1'b0, 32'h1234_5678, 32'h0000_0020, 0);
        do_req(3'b100, 1'b0, 32'hAAAA_5555, 32'h1234_0000, 0);
        do_req(3'b101, 1'b1, 32'h8000_0000, 32'd3, 0);
        do_req(3'b111, 1'b0, 32'hF0F0_0F0F, 32'hFF00_FF00, 5);

        // Reset in the middle of SLL by 20, at the tenth shift edge.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_funct7b5 = 1'b0;
        req_rs1 = 32'h0000_0003; req_rs2 = 32'd20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_in0", alu_in0, 32'd0);
        chk("midrst_in1", alu_in1, 32'd0);
        chk("midrst_op", {29'd0, alu_op}, 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_req(3'b000, 1'b0, 32'hFFFF_FFF0, 32'h0000_0013, 0);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            do_req(f3, 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
